serial_parity_deframer: RTL and testbench
=========================================

Name: serial_parity_deframer

Overview:
- Serial-input stage that collects a frame of DATA_BITS data bits plus one even-parity bit and presents it as a parallel word.
- Sits between a bit-serial source and word-level consumers.
- Running parity is a 1-bit XOR accumulator, the sequential counterpart of the team's XOR primitive.
- Parallel word is held on the output with a valid/ready handshake; the input is back-pressured while the word is held.

Parameters:
- DATA_BITS, 8, number of data bits per frame (>=2).
- ERR_CNT_W, 8, width of the parity-error counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit; LSB of data first, parity bit last.
- in_ready  output  1  block accepts in_bit this cycle.
- out_valid  output  1  out_data/out_parity_err valid.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  DATA_BITS  deframed data word.
- out_parity_err  output  1  1 = frame failed even parity.
- err_cnt  output  ERR_CNT_W  count of errored frames; only meaningful with PARITY_ERR_CNT_EN.

Behaviour:
- Accept condition: a bit is accepted when in_valid & in_ready at the rising edge of clk.
- States:
  - DATA: collecting data bits. A 0..DATA_BITS-1 bit counter tracks position; parity register p tracks running parity.
  - PAR: waiting for the parity bit.
  - HOLD: word presented on the output.
- in_ready: combinational, in_ready = (state != HOLD).
- DATA, on accept:
  - out_data[cnt] <= in_bit.
  - p <= p ^ in_bit.
  - cnt <= cnt+1.
  - When cnt == DATA_BITS-1: cnt <= 0 and state -> PAR.
- PAR, on accept:
  - out_parity_err <= p ^ in_bit.
  - out_valid <= 1.
  - state -> HOLD.
- HOLD:
  - out_data, out_parity_err and out_valid are stable while out_ready = 0.
  - in_valid is ignored; no bit is consumed.
  - When out_ready = 1: out_valid <= 0, p <= 0, state -> DATA.
  - in_ready rises the following cycle; there is no same-cycle bypass.
- Latency and throughput:
  - out_valid rises one cycle after the parity bit is accepted.
  - Minimum frame period is DATA_BITS+2 cycles.
- Stall: in_valid = 0 in DATA or PAR leaves all state unchanged. Gaps of any length are allowed mid-frame.
- out_ready while out_valid = 0 has no effect.
- Reset, whether asserted at power-up or mid-frame:
  - state = DATA, cnt = 0, p = 0.
  - out_valid = 0, out_data = 0, out_parity_err = 0, err_cnt = 0.
  - A partially received frame is discarded.
  - in_ready = 1 after reset. The source must hold in_valid = 0 while rst = 1.
- Bit ordering: the first accepted bit of a frame lands in out_data[0].

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined:
  - err_cnt increments by 1 on the edge where out_valid rises with out_parity_err = 1.
  - err_cnt saturates at all-ones and never wraps.
  - err_cnt is cleared only by rst.
- Undefined:
  - err_cnt is tied to constant 0.
  - No counter logic is synthesised.

Test Plan:
- Correct parity:
  - Stimulus: bits 1,0,1,0,0,1,0,1 (0xA5) then parity 0, back-to-back, out_ready = 1.
  - Response: out_valid rises 1 cycle after the parity bit, out_data = 8'hA5, out_parity_err = 0.
- Parity error:
  - Stimulus: same data, parity bit 1.
  - Response: out_data = 8'hA5, out_parity_err = 1. err_cnt = 1 if PARITY_ERR_CNT_EN is defined, else 0.
- Back-pressure:
  - Stimulus: frame 0x3C parity 0, out_ready = 0 for 5 cycles while the source drives in_valid = 1 with bit 1, then out_ready = 1.
  - Response: out_valid and out_data = 8'h3C held for 5 cycles, in_ready = 0 throughout. No extra bits are consumed; the next frame starts cleanly after release.
- Input gaps:
  - Stimulus: frame 0x81 parity 0 with in_valid deasserted for 3 cycles between every bit.
  - Response: out_data = 8'h81, out_parity_err = 0.
- Reset mid-frame:
  - Stimulus: 4 bits accepted, rst pulsed, then a full frame 0xF0 parity 0.
  - Response: exactly one word, out_data = 8'hF0, out_parity_err = 0.
- Counter saturation:
  - Stimulus: PARITY_ERR_CNT_EN defined, ERR_CNT_W = 2, five errored frames.
  - Response: err_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/serial_parity_deframer.sv
// Bit-serial to parallel deframer: DATA_BITS data bits (LSB first) plus one even-parity bit,
// presented as a held word with valid/ready. Optional macro PARITY_ERR_CNT_EN adds a saturating error counter.
module serial_parity_deframer #(
  parameter int DATA_BITS = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_parity_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_PAR  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 p_q, p_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 valid_q, valid_d;
  logic                 accept;

  assign in_ready = (state_q != S_HOLD);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    data_d  = data_q;
    perr_d  = perr_q;
    valid_d = valid_q;
    case (state_q)
      S_DATA: begin
        if (accept) begin
          data_d[cnt_q] = in_bit;
          p_d           = p_q ^ in_bit;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_PAR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PAR: begin
        if (accept) begin
          perr_d  = p_q ^ in_bit;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Release takes effect next cycle; in_ready stays low on the release cycle.
        if (out_ready) begin
          valid_d = 1'b0;
          p_d     = 1'b0;
          state_d = S_DATA;
        end
      end
      default: begin
        state_d = S_DATA;
        cnt_d   = '0;
        p_d     = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DATA;
      cnt_q   <= '0;
      p_q     <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_parity_err = perr_q;

`ifdef PARITY_ERR_CNT_EN
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Count on the same edge that raises out_valid with a parity failure.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == S_PAR) && accept && (p_q ^ in_bit))
      err_cnt_d = sat_inc(err_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_serial_parity_deframer.sv
// Randomized + directed bench for serial_parity_deframer against a frame-level reference model.
module tb_serial_parity_deframer;

  localparam int DB    = 8;
  localparam int ERR_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [DB-1:0]    out_data;
  logic             out_parity_err;
  logic [ERR_W-1:0] err_cnt;

  serial_parity_deframer #(.DATA_BITS(DB), .ERR_CNT_W(ERR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_bit        (in_bit),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_parity_err(out_parity_err),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: collected bits of the current frame, held word, error tally.
  bit   m_bits[$];
  bit   m_hold;
  logic [DB-1:0] m_word;
  bit   m_perr;
  int   m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_err_cnt();
`ifdef PARITY_ERR_CNT_EN
    return m_err;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    m_bits.delete();
    m_hold = 0;
    m_word = '0;
    m_perr = 0;
    m_err  = 0;
  endfunction

  function automatic void model_edge(input bit iv, input bit ib, input bit ordy);
    int par;
    if (m_hold) begin
      if (ordy) m_hold = 0;
    end else if (iv) begin
      m_bits.push_back(ib);
      if (m_bits.size() == DB + 1) begin
        m_word = '0;
        par = 0;
        for (int i = 0; i <= DB; i++) begin
          if (i < DB) m_word = m_word | (DB'(m_bits[i]) << i);
          par = par + int'(m_bits[i]);
        end
        m_perr = (par % 2) != 0;
        m_hold = 1;
        if (m_perr && m_err < (1 << ERR_W) - 1) m_err++;
        m_bits.delete();
      end
    end
  endfunction

  // One clock: drive, check in_ready, clock, advance model, check outputs.
  task automatic cycle(input bit iv, input bit ib, input bit ordy);
    in_valid  = iv;
    in_bit    = ib;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, !m_hold);
    @(posedge clk);
    model_edge(iv, ib, ordy);
    #1;
    check("out_valid", out_valid, m_hold);
    if (m_hold) begin
      check("out_data", out_data, m_word);
      check("out_parity_err", out_parity_err, m_perr);
    end
    check("err_cnt", err_cnt, exp_err_cnt());
  endtask

  task automatic send_bit(input bit b, input int gap, input bit ordy);
    int tries;
    for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, ordy);
    tries = 0;
    while (m_hold && tries < 20) begin
      cycle(1'b1, b, ordy);
      tries++;
    end
    if (m_hold) check("timeout_ready", 1, 0);
    cycle(1'b1, b, ordy);
  endtask

  task automatic send_frame(input logic [DB-1:0] w, input bit par, input int gap);
    for (int i = 0; i < DB; i++) send_bit(w[i], gap, 1'b1);
    send_bit(par, gap, 1'b1);
  endtask

  task automatic do_reset();
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_perr", out_parity_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    model_reset();
    do_reset();

    // Correct parity, back-to-back
    send_frame(8'hA5, 1'b0, 0);
    check("a5_valid", out_valid, 1);
    check("a5_data", out_data, 32'hA5);
    check("a5_perr", out_parity_err, 0);
    cycle(1'b0, 1'b0, 1'b1);

    // Parity error
    send_frame(8'hA5, 1'b1, 0);
    check("a5e_data", out_data, 32'hA5);
    check("a5e_perr", out_parity_err, 1);
`ifdef PARITY_ERR_CNT_EN
    check("a5e_err_cnt", err_cnt, 1);
`else
    check("a5e_err_cnt", err_cnt, 0);
`endif
    cycle(1'b0, 1'b0, 1'b1);

    // Back-pressure with the source pushing 1s
    send_frame(8'h3C, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      check("bp_hold_data", out_data, 32'h3C);
      check("bp_hold_valid", out_valid, 1);
    end
    cycle(1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 0);
    check("bp_next_data", out_data, 32'h5A);
    check("bp_next_perr", out_parity_err, 0);
    cycle(1'b0, 1'b0, 1'b1);

    // Gaps of 3 idle cycles between bits
    send_frame(8'h81, 1'b0, 3);
    check("gap_data", out_data, 32'h81);
    check("gap_perr", out_parity_err, 0);
    cycle(1'b0, 1'b0, 1'b1);

    // Reset mid-frame
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b1);
    do_reset();
    send_frame(8'hF0, 1'b0, 0);
    check("rmf_data", out_data, 32'hF0);
    check("rmf_perr", out_parity_err, 0);
    cycle(1'b0, 1'b0, 1'b1);

`ifdef PARITY_ERR_CNT_EN
    // Saturation with a 2-bit counter
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h01, 1'b0, 0);
      check("sat_err_cnt", err_cnt, (k < 3) ? k + 1 : 3);
      cycle(1'b0, 1'b0, 1'b1);
    end
`endif

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++)
      cycle(($urandom % 3) != 0, $urandom % 2, ($urandom % 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
